// File: rtl/lane_credit_arbiter.sv
// lane_credit_arbiter: round-robin, credit-gated arbiter sharing one egress lane between two FWFT ingress FIFOs.
module lane_credit_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int CREDITS   = 4,
  parameter int BURST     = 4,
  parameter int CW        = $clog2(CREDITS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_empty0,
  input  logic                 i_empty1,
  input  logic [DATA_SIZE-1:0] i_data0,
  input  logic [DATA_SIZE-1:0] i_data1,
  input  logic                 i_credit_in,
  output logic                 o_pop0,
  output logic                 o_pop1,
  output logic                 o_valid_out,
  output logic [DATA_SIZE-1:0] o_data_out,
  output logic [CW-1:0]        o_credits,
  output logic                 o_stall,
  output logic                 o_err_credit
);
  localparam int BW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
  state_t        r_state;
  logic          r_last;
  logic [BW-1:0] r_burst;
  logic          w_e0, w_e1, w_can, w_cont, w_lane, w_send;
  logic [BW-1:0] w_nb;
  assign w_e0   = !i_empty0;
  assign w_e1   = !i_empty1;
  assign w_can  = o_credits != '0;
  // In SERVE states r_last always names the lane being served, so it doubles as the current lane.
  assign w_cont = (r_state != IDLE) && (r_last ? w_e1 : w_e0) && (r_burst < BW'(BURST - 1));
  assign w_lane = w_cont ? r_last : ((r_last ? w_e0 : w_e1) ? !r_last : r_last);
  assign w_send = i_rst_n && w_can && (w_e0 || w_e1);
  assign w_nb   = w_cont ? r_burst + BW'(1) : '0;
  assign o_pop0 = w_send && !w_lane;
  assign o_pop1 = w_send && w_lane;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_out  <= 1'b0;
      o_data_out   <= '0;
      o_credits    <= CW'(CREDITS);
      o_stall      <= 1'b0;
      o_err_credit <= 1'b0;
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_burst      <= '0;
    end else begin
      o_stall     <= (w_e0 || w_e1) && !w_can;
      o_valid_out <= w_send;
      if (w_send) begin
        o_data_out <= w_lane ? i_data1 : i_data0;
        r_last     <= w_lane;
        r_state    <= w_lane ? SERVE1 : SERVE0;
        r_burst    <= w_nb;
      end else begin
        r_state <= IDLE;
        r_burst <= '0;
      end
      if (o_credits == CW'(CREDITS) && i_credit_in && !w_send)
        o_err_credit <= 1'b1;
      else
        o_credits <= o_credits - CW'(w_send) + CW'(i_credit_in);
    end
  end
endmodule

// File: doc/lane_credit_arbiter.md
# lane_credit_arbiter

Round-robin, credit-gated arbiter that shares one egress lane between two ingress FIFOs, each presenting a first-word-fall-through head.
- It sits between the per-lane ingress FIFOs and the downstream serializer/egress buffer of the switching device.
- It pops at most one word per cycle and limits consecutive grants to one requester.
- It never sends more words than the egress buffer has free slots.

## Interface
Parameters:
- DATA_SIZE, 10, width of one word (control bits + MAIN_SIZE payload)
- CREDITS, 4, egress buffer depth; initial and maximum credit count
- BURST, 4, maximum consecutive grants to one lane while the other lane waits
- CW, $clog2(CREDITS+1), credit counter width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- empty0, empty1  in  1  ingress FIFO empty flags
- data0, data1  in  DATA_SIZE  ingress FIFO head words, valid when the matching empty is 0
- credit_in  in  1  egress freed one slot this cycle
- pop0, pop1  out  1  combinational pop to the ingress FIFO; at most one high per cycle
- valid_out  out  1  registered; data_out holds a word this cycle
- data_out  out  DATA_SIZE  registered copy of the popped word
- credits  out  CW  current credit count
- stall  out  1  registered; a request was pending last cycle but credits were 0
- err_credit  out  1  sticky; credit_in was received with credits at CREDITS and no send

## Operation
- Definitions:
  - eligible_i = !empty_i.
  - can_send = (credits != 0). This uses the registered count only; a credit_in in the same cycle does not enable a send.
- States: IDLE, SERVE0, SERVE1. State encodes the lane granted in the previous cycle. Also held:
  - last: lane most recently served. Reset value 1, so lane 0 wins the first tie.
  - burst_cnt: grants in the current run, 0..BURST-1.
- Grant selection in a cycle with can_send=1:
  - SERVE_i with eligible_i, burst_cnt < BURST-1: grant i; burst_cnt+1.
  - SERVE_i with burst_cnt = BURST-1 or !eligible_i: grant the other lane if eligible; burst_cnt = 0. Otherwise grant i if eligible; burst_cnt = 0 (restart run).
  - IDLE: grant the lane != last if eligible, else grant last if eligible; burst_cnt = 0.
  - Granted lane j: pop_j = 1. Next edge: data_out <= data_j, valid_out <= 1, last <= j, state <= SERVEj.
- No grant (can_send=0 or nothing eligible):
  - pop0 = pop1 = 0.
  - Next edge: valid_out <= 0, data_out holds, state <= IDLE, burst_cnt <= 0.
  - stall <= (eligible0 | eligible1) & !can_send.
- Credit update:
  - credits_next = credits - send + credit_in, where send = pop0|pop1.
  - If credits = CREDITS, credit_in = 1 and send = 0: credits stays at CREDITS and err_credit <= 1. err_credit clears only on reset.
- Reset (asynchronous, any time, including mid-burst):
  - pop0, pop1 forced 0 while reset = 0.
  - valid_out 0, data_out 0, credits CREDITS, stall 0, err_credit 0, state IDLE, last 1, burst_cnt 0.
  - The first possible grant is in the first cycle after reset deasserts.

## Timing
- Pop to data: pop_j is asserted in cycle t; data_out/valid_out show that word in cycle t+1 (1-cycle latency).
- Throughput: one word per cycle while credits > 0.
- Back-to-back pops are legal; the FIFO head is assumed to update by the next edge.
- Credits:
  - Send with credit_in in the same cycle: count unchanged.
  - Count 0 with credit_in in cycle t: earliest new pop is in cycle t+1.
- Fairness: with both lanes continuously eligible, the grant pattern is BURST grants to lane 0 (from reset), then BURST to lane 1, repeating.
- Lane switch: a lane going empty mid-run switches the grant in the same cycle, with no bubble.
- pop0/pop1 are combinational from registered state, empty flags and credits. No combinational path from credit_in to pop.

## Test plan
- Reset/first grant:
  - Stimulus: hold reset=0 for 2 cycles with both lanes non-empty; release, CREDITS=4, credit_in=0.
  - Response: pops are 0 during reset. After release, pop0 in cycles 1-4 with data_out=0x0FF,0x3DD,0x0EE,0x3CC one cycle later. Then credits=0, stall=1 and no pop.
- Burst fairness:
  - Stimulus: both lanes always non-empty, credit_in=1 every cycle.
  - Response: grant sequence 0,0,0,0,1,1,1,1,0,... and credits stay at 4.
- Single requester:
  - Stimulus: only lane 1 non-empty for 10 words, credits refilled.
  - Response: 10 consecutive pop1, no bubbles at burst boundaries, valid_out high for 10 cycles.
- Credit starvation and recovery:
  - Stimulus: drain credits to 0, then pulse credit_in in cycle t.
  - Response: stall=1 before t; exactly one pop in cycle t+1; credits back to 0.
- Credit overflow:
  - Stimulus: credits=4, no request, credit_in=1.
  - Response: err_credit=1 next cycle and sticky, credits remain 4. A later reset clears err_credit.
- Reset mid-burst:
  - Stimulus: assert reset in the middle of a lane-0 run.
  - Response: pop0 drops immediately; valid_out=0, credits=4. After release, lane 0 is granted first again (last=1).
